// File: rtl/pipeline_controller.sv
// Five-stage pipeline hazard controller: per-stage stall generation, exception flush
// sequencing with front-end drain, and a stall watchdog with a saturating stall counter.
module pipeline_controller #(
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall_req_if,
   input  logic        stall_req_id,
   input  logic        stall_req_ex,
   input  logic        stall_req_mem,
   input  logic        exc_req,
   input  logic [31:0] exc_pc,
   output logic [4:0]  stall,
   output logic        flush,
   output logic [31:0] flush_pc,
   output logic        exc_busy,
   output logic        stall_timeout,
   output logic [31:0] stall_cycles
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] WAIT  = 2'd1;
   localparam logic [1:0] FLUSH = 2'd2;

   localparam logic [15:0] WD_LIMIT = 16'(TIMEOUT_CYCLES - 1);

   logic [1:0]  state_q, state_d;
   logic [31:0] flush_pc_q, flush_pc_d;
   logic [15:0] wd_q, wd_d;
   logic        timeout_q, timeout_d;
   logic [31:0] cycles_q, cycles_d;
   logic [4:0]  stall_raw;
   logic        front_hold;
   logic        any_stall;

   // A later-stage stall freezes every earlier stage; wb never stalls.
   assign stall_raw = {1'b0,
                       stall_req_mem,
                       stall_req_mem | stall_req_ex,
                       stall_req_mem | stall_req_ex | stall_req_id,
                       stall_req_mem | stall_req_ex | stall_req_id | stall_req_if};

   // The redirect must wait until fetch and memory have no transaction in flight.
   assign front_hold = stall_req_if | stall_req_mem;

   always_comb begin
      flush    = (state_q == FLUSH);
      exc_busy = (state_q == WAIT) || (state_q == FLUSH);
      stall    = (!rst || flush) ? 5'b00000 : stall_raw;
      any_stall = |stall;
   end

   always_comb begin
      state_d    = state_q;
      flush_pc_d = flush_pc_q;
      unique case (state_q)
         IDLE: begin
            if (exc_req) begin
               flush_pc_d = exc_pc;
               state_d    = front_hold ? WAIT : FLUSH;
            end
         end
         WAIT: begin
            if (!front_hold) begin
               state_d = FLUSH;
            end
         end
         FLUSH: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Watchdog parks at its limit instead of wrapping; the timeout flag is sticky.
   always_comb begin
      wd_d      = wd_q;
      timeout_d = timeout_q;
      cycles_d  = cycles_q;
      if (any_stall) begin
         if (wd_q == WD_LIMIT) begin
            timeout_d = 1'b1;
         end else begin
            wd_d = wd_q + 16'd1;
         end
         if (cycles_q != 32'hFFFF_FFFF) begin
            cycles_d = cycles_q + 32'd1;
         end
      end else begin
         wd_d = 16'd0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         flush_pc_q <= 32'd0;
         wd_q       <= 16'd0;
         timeout_q  <= 1'b0;
         cycles_q   <= 32'd0;
      end else begin
         state_q    <= state_d;
         flush_pc_q <= flush_pc_d;
         wd_q       <= wd_d;
         timeout_q  <= timeout_d;
         cycles_q   <= cycles_d;
      end
   end

   assign flush_pc      = flush_pc_q;
   assign stall_timeout = timeout_q;
   assign stall_cycles  = cycles_q;

endmodule
